// File: rtl/i2s_dual_mic_rx_pkg.sv
// Shared constants and FSM encoding for the dual-microphone I2S capture front end.
package i2s_dual_mic_rx_pkg;

    localparam int WORDSIZE_DEF  = 8;
    localparam int SLOT_BITS_DEF = 24;

    typedef enum logic [1:0] {
        ST_SYNC  = 2'd0,
        ST_LEFT  = 2'd1,
        ST_RIGHT = 2'd2
    } rx_state_t;

endpackage

// File: rtl/i2s_dual_mic_rx_edge_sync.sv
// Brings the asynchronous I2S pins into the clk domain and flags sck rising edges.
module i2s_edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic i2s_sck,
    input  logic i2s_ws,
    input  logic i2s_sd,
    output logic sck_rise,
    output logic ws_s,
    output logic sd_s
);

    logic [1:0] sck_sync;
    logic [1:0] ws_sync;
    logic [1:0] sd_sync;
    logic       sck_prev;

    // Two-flop synchronizers for all three pins, plus the previous synchronized sck
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_sync <= '0;
            ws_sync  <= '0;
            sd_sync  <= '0;
            sck_prev <= 1'b0;
        end else begin
            sck_sync <= {sck_sync[0], i2s_sck};
            ws_sync  <= {ws_sync[0], i2s_ws};
            sd_sync  <= {sd_sync[0], i2s_sd};
            sck_prev <= sck_sync[1];
        end
    end

    // ws and sd travel through the same depth as sck, so they line up with the edge pulse
    assign sck_rise = sck_sync[1] & ~sck_prev;
    assign ws_s     = ws_sync[1];
    assign sd_s     = sd_sync[1];

endmodule

// File: rtl/i2s_dual_mic_rx.sv
// Stereo I2S receiver: left slot -> main, right slot -> sub, delivered as a held pair
// over a valid/ready handshake with a sticky overrun flag for dropped pairs.
module i2s_dual_mic_rx
    import i2s_dual_mic_rx_pkg::*;
#(
    parameter int WORDSIZE  = WORDSIZE_DEF,
    parameter int SLOT_BITS = SLOT_BITS_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       enable,
    input  logic                       i2s_sck,
    input  logic                       i2s_ws,
    input  logic                       i2s_sd,
    input  logic                       sample_ready,
    input  logic                       overrun_clr,
    output logic signed [WORDSIZE-1:0] main,
    output logic signed [WORDSIZE-1:0] sub,
    output logic                       sample_valid,
    output logic                       overrun
);

    localparam int                 CNT_W   = $clog2(SLOT_BITS + 1);
    localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(SLOT_BITS);

    logic                  sck_rise;
    logic                  ws_s;
    logic                  sd_s;

    logic                  ws_d;
    logic                  ws_dd;
    logic                  slot_start;
    logic                  slot_end;

    logic [CNT_W-1:0]      cnt;
    logic [CNT_W-1:0]      eff_cnt;
    logic [CNT_W-1:0]      cnt_next;
    logic [SLOT_BITS-1:0]  slot_reg;
    logic [SLOT_BITS-1:0]  slot_next;

    rx_state_t             state;
    rx_state_t             state_next;
    logic                  left_latch;
    logic                  pair_done;

    logic [WORDSIZE-1:0]   left_hold;

    i2s_edge_sync u_edge_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .i2s_sck  (i2s_sck),
        .i2s_ws   (i2s_ws),
        .i2s_sd   (i2s_sd),
        .sck_rise (sck_rise),
        .ws_s     (ws_s),
        .sd_s     (sd_s)
    );

    // The bit at this edge belongs to ws_d; a change between ws_dd and ws_d marks its MSB,
    // a change between ws_s and ws_d marks it as the last bit of the slot.
    assign slot_start = ws_d ^ ws_dd;
    assign slot_end   = ws_s ^ ws_d;

    // Slot register value after writing this edge's bit, left-justified, cleared at slot start
    always_comb begin
        eff_cnt   = slot_start ? '0 : cnt;
        slot_next = slot_start ? '0 : slot_reg;
        for (int i = 0; i < SLOT_BITS; i++) begin
            if (int'(eff_cnt) == SLOT_BITS - 1 - i) begin
                slot_next[i] = sd_s;
            end
        end
        cnt_next = (eff_cnt < CNT_MAX) ? eff_cnt + 1'b1 : eff_cnt;
    end

    // Capture path: ws history, bit counter and slot register advance only on sck edges
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ws_d     <= 1'b0;
            ws_dd    <= 1'b0;
            cnt      <= '0;
            slot_reg <= '0;
        end else if (sck_rise) begin
            ws_dd    <= ws_d;
            ws_d     <= ws_s;
            cnt      <= cnt_next;
            slot_reg <= slot_next;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_SYNC;
        end else begin
            state <= state_next;
        end
    end

    // FSM next state: align on a left MSB, then walk left slot -> right slot -> pair
    always_comb begin
        state_next = state;
        left_latch = 1'b0;
        pair_done  = 1'b0;
        if (!enable) begin
            state_next = ST_SYNC;
        end else if (sck_rise) begin
            case (state)
                ST_SYNC: begin
                    if (slot_start && !ws_d) begin
                        state_next = ST_LEFT;
                    end
                end
                ST_LEFT: begin
                    if (slot_end) begin
                        left_latch = 1'b1;
                        state_next = ST_RIGHT;
                    end
                end
                ST_RIGHT: begin
                    if (slot_end) begin
                        pair_done  = 1'b1;
                        state_next = ST_LEFT;
                    end
                end
                default: state_next = ST_SYNC;
            endcase
        end
    end

    // Hold the left sample until its right partner completes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            left_hold <= '0;
        end else if (left_latch) begin
            left_hold <= slot_next[SLOT_BITS-1 -: WORDSIZE];
        end
    end

    // Output buffer: load a completed pair when the slot is free or being emptied this cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main         <= '0;
            sub          <= '0;
            sample_valid <= 1'b0;
        end else if (pair_done && (!sample_valid || sample_ready)) begin
            main         <= left_hold;
            sub          <= slot_next[SLOT_BITS-1 -: WORDSIZE];
            sample_valid <= 1'b1;
        end else if (sample_valid && sample_ready) begin
            sample_valid <= 1'b0;
        end
    end

    // Sticky overrun: a drop takes priority over a clear in the same cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun <= 1'b0;
        end else if (pair_done && sample_valid && !sample_ready) begin
            overrun <= 1'b1;
        end else if (overrun_clr) begin
            overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_i2s_dual_mic_rx.sv
// Testbench for i2s_dual_mic_rx: drives I2S frames, predicts delivered pairs, scoreboards them.
module tb_i2s_dual_mic_rx;

    logic              clk;
    logic              rst_n;
    logic              enable;
    logic              i2s_sck;
    logic              i2s_ws;
    logic              i2s_sd;
    logic              sample_ready;
    logic              overrun_clr;
    logic signed [7:0] main;
    logic signed [7:0] sub;
    logic              sample_valid;
    logic              overrun;

    int checks = 0;
    int errors = 0;
    int valid_cycles = 0;
    logic [15:0] exp_q[$];

    i2s_dual_mic_rx dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .i2s_sck      (i2s_sck),
        .i2s_ws       (i2s_ws),
        .i2s_sd       (i2s_sd),
        .sample_ready (sample_ready),
        .overrun_clr  (overrun_clr),
        .main         (main),
        .sub          (sub),
        .sample_valid (sample_valid),
        .overrun      (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #800000;
        $display("FAIL watchdog simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: top 8 bits of a slot left-justified from its first transmitted bit
    function automatic logic [7:0] top8(input int n, input logic [31:0] v);
        logic [63:0] w;
        w = {32'h0, v};
        if (n >= 8) return 8'(w >> (n - 8));
        return 8'(w << (8 - n));
    endfunction

    // Scoreboard monitor: every accepted pair must match the oldest prediction
    always @(negedge clk) begin
        if (rst_n && sample_valid) valid_cycles++;
        if (rst_n && sample_valid && sample_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pair got %h%h expected none", main, sub);
            end else begin
                check("pair", {16'h0, main, sub}, {16'h0, exp_q.pop_front()});
            end
        end
    end

    // One I2S bit: change ws/sd with sck low, then rise sck; sck edges sit on clk negedges
    task automatic send_bit(input logic w, input logic d, input logic coincide);
        @(negedge clk);
        i2s_sck = 1'b0;
        i2s_ws  = w;
        i2s_sd  = d;
        repeat (4) @(negedge clk);
        i2s_sck = 1'b1;
        if (coincide) begin
            // ready for exactly the clk cycle in which the pair completes
            @(posedge clk);
            @(posedge clk);
            #1 sample_ready = 1'b1;
            @(posedge clk);
            #1 sample_ready = 1'b0;
            @(negedge clk);
        end else begin
            repeat (3) @(negedge clk);
        end
    endtask

    // act: 0 none, 1 drop enable, 2 assert reset, 3 release reset, 4 ready on pair completion
    task automatic send_frame(input int lb, input logic [31:0] lv, input int rb,
                              input logic [31:0] rv, input int act_at, input int act);
        logic d;
        logic w;
        for (int k = 0; k < lb + rb; k++) begin
            if (k == act_at) begin
                if (act == 1) enable = 1'b0;
                if (act == 3) rst_n = 1'b1;
                if (act == 2) begin
                    exp_q.delete();
                    @(negedge clk);
                    #2 rst_n = 1'b0;
                    #1;
                    check("rst_main", {24'h0, main}, 32'h0);
                    check("rst_sub", {24'h0, sub}, 32'h0);
                    check("rst_valid", {31'h0, sample_valid}, 32'h0);
                    check("rst_overrun", {31'h0, overrun}, 32'h0);
                end
            end
            d = (k < lb) ? lv[lb - 1 - k] : rv[rb - 1 - (k - lb)];
            w = (k + 1 < lb) ? 1'b0 : ((k + 1 < lb + rb) ? 1'b1 : 1'b0);
            send_bit(w, d, (k == act_at) && (act == 4));
        end
    endtask

    task automatic frame_exp(input int lb, input logic [31:0] lv, input int rb, input logic [31:0] rv);
        exp_q.push_back({top8(lb, lv), top8(rb, rv)});
        send_frame(lb, lv, rb, rv, -1, 0);
    endtask

    task automatic settle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drain();
        sample_ready = 1'b1;
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clk);
        settle(3);
        check("drain_pending", exp_q.size(), 0);
    endtask

    initial begin
        int lb;
        int rb;
        int vc0;
        logic [31:0] lv;
        logic [31:0] rv;

        rst_n = 1'b0; enable = 1'b1; sample_ready = 1'b0; overrun_clr = 1'b0;
        i2s_sck = 1'b0; i2s_ws = 1'b0; i2s_sd = 1'b0;
        settle(5);
        check("reset_main", {24'h0, main}, 32'h0);
        check("reset_sub", {24'h0, sub}, 32'h0);
        check("reset_valid", {31'h0, sample_valid}, 32'h0);
        check("reset_overrun", {31'h0, overrun}, 32'h0);

        // Mid-frame start: reset released halfway through a left slot, that frame yields nothing
        sample_ready = 1'b1;
        send_frame(24, 32'h00C3C3C3, 24, 32'h003C3C3C, 12, 3);
        vc0 = valid_cycles;
        check("midframe_none", vc0, 0);

        // Nominal frames with ready tied high: exactly one valid cycle per frame
        frame_exp(24, 32'h005A1234, 24, 32'h00A5FFFF);
        frame_exp(24, 32'h00FFFFFF, 24, 32'h00FFFFFF);
        frame_exp(16, 32'h00007F00, 16, 32'h00008001);
        frame_exp(6, 32'h0000002A, 6, 32'h00000015);
        settle(10);
        check("valid_per_frame", valid_cycles - vc0, 4);

        // Randomized slot lengths, including slots longer than the capture width
        for (int f = 0; f < 6; f++) begin
            lb = $urandom_range(4, 32);
            rb = $urandom_range(4, 32);
            lv = $urandom;
            rv = $urandom;
            if (lb < 32) lv = lv & ((32'h1 << lb) - 1);
            if (rb < 32) rv = rv & ((32'h1 << rb) - 1);
            frame_exp(lb, lv, rb, rv);
        end
        drain();

        // Overrun: two frames with no consumer, second pair dropped
        sample_ready = 1'b0;
        frame_exp(24, 32'h00115678, 24, 32'h00229ABC);
        send_frame(24, 32'h00334455, 24, 32'h00446677, -1, 0);
        settle(5);
        check("ovr_main", {24'h0, main}, 32'h11);
        check("ovr_sub", {24'h0, sub}, 32'h22);
        check("ovr_valid", {31'h0, sample_valid}, 32'h1);
        check("ovr_flag", {31'h0, overrun}, 32'h1);
        drain();
        settle(5);
        check("ovr_sticky", {31'h0, overrun}, 32'h1);
        check("ovr_valid_low", {31'h0, sample_valid}, 32'h0);
        overrun_clr = 1'b1;
        settle(1);
        overrun_clr = 1'b0;
        settle(1);
        check("ovr_cleared", {31'h0, overrun}, 32'h0);

        // Ready asserted in the very cycle a new pair completes
        sample_ready = 1'b0;
        frame_exp(24, 32'h00616263, 24, 32'h00717273);
        exp_q.push_back({8'h81, 8'h91});
        send_frame(24, 32'h00818283, 24, 32'h00919293, 47, 4);
        settle(2);
        check("simul_valid", {31'h0, sample_valid}, 32'h1);
        check("simul_main", {24'h0, main}, 32'h81);
        check("simul_sub", {24'h0, sub}, 32'h91);
        check("simul_overrun", {31'h0, overrun}, 32'h0);
        drain();

        // Enable dropped during a left slot: partial pair discarded, held pair still delivered
        sample_ready = 1'b0;
        frame_exp(24, 32'h00C0FFEE, 24, 32'h00D00D00);
        send_frame(24, 32'h00E1E2E3, 24, 32'h00F1F2F3, 3, 1);
        enable = 1'b1;
        settle(3);
        check("en_valid", {31'h0, sample_valid}, 32'h1);
        check("en_main", {24'h0, main}, 32'hC0);
        check("en_overrun", {31'h0, overrun}, 32'h0);
        drain();
        frame_exp(24, 32'h00123456, 24, 32'h00FEDCBA);
        drain();

        // Reset during a right slot: outputs clear at once, then restart from SYNC
        sample_ready = 1'b0;
        frame_exp(24, 32'h00AB0000, 24, 32'h00CD0000);
        settle(3);
        check("prerst_valid", {31'h0, sample_valid}, 32'h1);
        send_frame(24, 32'h00777777, 24, 32'h00888888, 27, 2);
        settle(3);
        rst_n = 1'b1;
        send_bit(1'b1, 1'b0, 1'b0);
        send_bit(1'b0, 1'b0, 1'b0);
        sample_ready = 1'b1;
        frame_exp(24, 32'h00391234, 24, 32'h00C8ABCD);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
